tlp_cpl_arb: RTL and testbench

- Round-robin, packet-locked arbiter that merges PORTS completion TLP streams onto the single completer TLP output of the PCIe/AXI bridge.
- Typical sources: read-completion engine, error/UR completion generator, config completer.
- Once a port wins at SOP, the grant holds until that port's EOP beat is accepted, so packets never interleave.
- The output is registered, with one beat of storage.

---
 rtl/tlp_cpl_arb.sv | 137 +++++++++++++
 tb/tb_tlp_cpl_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tlp_cpl_arb.sv
// Packet-locked round-robin merge of completion TLP sources
// onto a single registered completer TLP output.
module tlp_cpl_arb #(
  parameter int PORTS          = 2,
  parameter int DOUBLE_WORD    = 32,
  parameter int HEADER_SIZE    = 4*DOUBLE_WORD,
  parameter int TLP_DATA_WIDTH = 8*DOUBLE_WORD,
  parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH/8,
  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORTS*TLP_DATA_WIDTH-1:0] in_tlp_data,
  input  logic [PORTS*HEADER_SIZE-1:0]    in_tlp_hdr,
  input  logic [PORTS*TLP_STRB_WIDTH-1:0] in_tlp_strb,
  input  logic [PORTS-1:0]                in_tlp_sop,
  input  logic [PORTS-1:0]                in_tlp_eop,
  input  logic [PORTS-1:0]                in_tlp_valid,
  output logic [PORTS-1:0]                in_tlp_ready,
  output logic [TLP_DATA_WIDTH-1:0]       cpl_tlp_data,
  output logic [HEADER_SIZE-1:0]          cpl_tlp_hdr,
  output logic [TLP_STRB_WIDTH-1:0]       cpl_tlp_strb,
  output logic                            cpl_tlp_sop,
  output logic                            cpl_tlp_eop,
  output logic                            cpl_tlp_valid,
  input  logic                            cpl_tlp_ready,
  output logic [GW-1:0]                   grant_idx,
  output logic                            proto_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                    state_q, state_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic                      first_q, first_d;
  logic                      valid_q;
  logic                      sop_q, eop_q;
  logic [TLP_DATA_WIDTH-1:0] data_q;
  logic [HEADER_SIZE-1:0]    hdr_q;
  logic [TLP_STRB_WIDTH-1:0] strb_q;

  logic                      can_load;
  logic                      accept;
  logic                      perr;
  logic                      found;
  logic [PORTS-1:0]          cands;
  logic [GW-1:0]             win;
  logic                      sel_valid, sel_sop, sel_eop;
  int                        idx;

  assign can_load  = !valid_q || cpl_tlp_ready;
  assign cands     = in_tlp_valid & in_tlp_sop;
  assign sel_valid = in_tlp_valid[grant_q];
  assign sel_sop   = in_tlp_sop[grant_q];
  assign sel_eop   = in_tlp_eop[grant_q];

  // Search starts just past the last winner so every port gets a turn.
  always_comb begin
    win   = grant_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= PORTS; i++) begin
      idx = (int'(grant_q) + i) % PORTS;
      if (!found && cands[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    first_d      = first_q;
    in_tlp_ready = '0;
    accept       = 1'b0;
    perr         = 1'b0;
    unique case (state_q)
      IDLE: begin
        perr = |(in_tlp_valid & ~in_tlp_sop);
        if (found) begin
          grant_d = win;
          first_d = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        in_tlp_ready[grant_q] = can_load;
        accept = can_load && sel_valid;
        if (accept) begin
          first_d = 1'b0;
          perr    = sel_sop && !first_q;
          if (sel_eop) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= GW'(PORTS-1);
      first_q <= 1'b0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
      hdr_q   <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      first_q <= first_d;
      if (accept) begin
        valid_q <= 1'b1;
        sop_q   <= sel_sop;
        eop_q   <= sel_eop;
        data_q  <= in_tlp_data[int'(grant_q)*TLP_DATA_WIDTH +: TLP_DATA_WIDTH];
        hdr_q   <= in_tlp_hdr[int'(grant_q)*HEADER_SIZE +: HEADER_SIZE];
        strb_q  <= in_tlp_strb[int'(grant_q)*TLP_STRB_WIDTH +: TLP_STRB_WIDTH];
      end else if (cpl_tlp_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign cpl_tlp_valid = valid_q;
  assign cpl_tlp_sop   = sop_q;
  assign cpl_tlp_eop   = eop_q;
  assign cpl_tlp_data  = data_q;
  assign cpl_tlp_hdr   = hdr_q;
  assign cpl_tlp_strb  = strb_q;
  assign grant_idx     = grant_q;
  assign proto_err     = perr && !rst;

endmodule

// File: tb/tb_tlp_cpl_arb.sv
// Directed vector bench for tlp_cpl_arb with PORTS=2; each
// port's beat carries a tag byte replicated across data/hdr/strb.
module tb_tlp_cpl_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_tlp_data;
  logic [255:0] in_tlp_hdr;
  logic [63:0]  in_tlp_strb;
  logic [1:0]   in_tlp_sop, in_tlp_eop, in_tlp_valid, in_tlp_ready;
  logic [255:0] cpl_tlp_data;
  logic [127:0] cpl_tlp_hdr;
  logic [31:0]  cpl_tlp_strb;
  logic         cpl_tlp_sop, cpl_tlp_eop, cpl_tlp_valid, cpl_tlp_ready;
  logic [0:0]   grant_idx;
  logic         proto_err;

  always #5 clk = ~clk;

  tlp_cpl_arb dut (
    .clk(clk), .rst(rst),
    .in_tlp_data(in_tlp_data), .in_tlp_hdr(in_tlp_hdr),
    .in_tlp_strb(in_tlp_strb), .in_tlp_sop(in_tlp_sop),
    .in_tlp_eop(in_tlp_eop), .in_tlp_valid(in_tlp_valid),
    .in_tlp_ready(in_tlp_ready),
    .cpl_tlp_data(cpl_tlp_data), .cpl_tlp_hdr(cpl_tlp_hdr),
    .cpl_tlp_strb(cpl_tlp_strb), .cpl_tlp_sop(cpl_tlp_sop),
    .cpl_tlp_eop(cpl_tlp_eop), .cpl_tlp_valid(cpl_tlp_valid),
    .cpl_tlp_ready(cpl_tlp_ready),
    .grant_idx(grant_idx), .proto_err(proto_err)
  );

  typedef struct {
    logic       rs, cr;
    logic [1:0] v, s, e;
    logic [7:0] t0, t1;
    logic [1:0] er;
    logic       ev, es, ee;
    logic [7:0] et;
    logic       eg, ep;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(logic rs, logic cr, logic [1:0] v,
                              logic [1:0] s, logic [1:0] e,
                              logic [7:0] t0, logic [7:0] t1,
                              logic [1:0] er, logic ev, logic es,
                              logic ee, logic [7:0] et, logic eg,
                              logic ep);
    vec_t r;
    r.rs = rs; r.cr = cr; r.v = v; r.s = s; r.e = e;
    r.t0 = t0; r.t1 = t1; r.er = er; r.ev = ev; r.es = es;
    r.ee = ee; r.et = et; r.eg = eg; r.ep = ep;
    return r;
  endfunction

  task automatic drive(vec_t r);
    rst           = r.rs;
    cpl_tlp_ready = r.cr;
    in_tlp_valid  = r.v;
    in_tlp_sop    = r.s;
    in_tlp_eop    = r.e;
    in_tlp_data   = {{32{r.t1}}, {32{r.t0}}};
    in_tlp_hdr    = {{16{r.t1}}, {16{r.t0}}};
    in_tlp_strb   = {{4{r.t1}}, {4{r.t0}}};
  endtask

  task automatic check(int n, vec_t r);
    logic bad;
    bad = 1'b0;
    nvec++;
    if (in_tlp_ready !== r.er) begin
      $display("FAIL row %0d ready got %b want %b", n, in_tlp_ready, r.er);
      bad = 1'b1;
    end
    if (cpl_tlp_valid !== r.ev) begin
      $display("FAIL row %0d valid got %b want %b", n, cpl_tlp_valid, r.ev);
      bad = 1'b1;
    end
    if (grant_idx !== r.eg) begin
      $display("FAIL row %0d grant got %0d want %0d", n, grant_idx, r.eg);
      bad = 1'b1;
    end
    if (proto_err !== r.ep) begin
      $display("FAIL row %0d proto_err got %b want %b", n, proto_err, r.ep);
      bad = 1'b1;
    end
    if (r.ev) begin
      if (cpl_tlp_sop !== r.es || cpl_tlp_eop !== r.ee) begin
        $display("FAIL row %0d sop/eop got %b%b want %b%b", n,
                 cpl_tlp_sop, cpl_tlp_eop, r.es, r.ee);
        bad = 1'b1;
      end
      if (cpl_tlp_data !== {32{r.et}} || cpl_tlp_hdr !== {16{r.et}} ||
          cpl_tlp_strb !== {4{r.et}}) begin
        $display("FAIL row %0d beat got %h want tag %h", n,
                 cpl_tlp_data[7:0], r.et);
        bad = 1'b1;
      end
    end
    if (bad) nerr++;
  endtask

  initial begin
    int c0, c1;
    logic ex;
    logic [1:0] acc;

    // single port, 3-beat packet
    vq.push_back(mk(1,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,1,0));
    vq.push_back(mk(0,1,2'b01,2'b01,2'b00,8'h11,8'h00, 2'b00,0,0,0,8'h00,1,0));
    vq.push_back(mk(0,1,2'b01,2'b01,2'b00,8'h11,8'h00, 2'b01,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b01,2'b00,2'b00,8'h12,8'h00, 2'b01,1,1,0,8'h11,0,0));
    vq.push_back(mk(0,1,2'b01,2'b00,2'b01,8'h13,8'h00, 2'b01,1,0,0,8'h12,0,0));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,1,0,1,8'h13,0,0));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,0,0));
    // contention, both 2-beat packets
    vq.push_back(mk(1,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b11,2'b11,2'b00,8'h21,8'h31, 2'b00,0,0,0,8'h00,1,0));
    vq.push_back(mk(0,1,2'b11,2'b11,2'b00,8'h21,8'h31, 2'b01,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b11,2'b10,2'b01,8'h22,8'h31, 2'b01,1,1,0,8'h21,0,0));
    vq.push_back(mk(0,1,2'b10,2'b10,2'b00,8'h00,8'h31, 2'b00,1,0,1,8'h22,0,0));
    vq.push_back(mk(0,1,2'b10,2'b10,2'b00,8'h00,8'h31, 2'b10,0,0,0,8'h00,1,0));
    vq.push_back(mk(0,1,2'b10,2'b00,2'b10,8'h00,8'h32, 2'b10,1,1,0,8'h31,1,0));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,1,0,1,8'h32,1,0));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,1,0));
    // backpressure 1,0,0,1 inside a 4-beat packet
    vq.push_back(mk(1,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,1,0));
    vq.push_back(mk(0,1,2'b01,2'b01,2'b00,8'h41,8'h00, 2'b00,0,0,0,8'h00,1,0));
    vq.push_back(mk(0,1,2'b01,2'b01,2'b00,8'h41,8'h00, 2'b01,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b01,2'b00,2'b00,8'h42,8'h00, 2'b01,1,1,0,8'h41,0,0));
    vq.push_back(mk(0,0,2'b01,2'b00,2'b00,8'h43,8'h00, 2'b00,1,0,0,8'h42,0,0));
    vq.push_back(mk(0,0,2'b01,2'b00,2'b00,8'h43,8'h00, 2'b00,1,0,0,8'h42,0,0));
    vq.push_back(mk(0,1,2'b01,2'b00,2'b00,8'h43,8'h00, 2'b01,1,0,0,8'h42,0,0));
    vq.push_back(mk(0,1,2'b01,2'b00,2'b01,8'h44,8'h00, 2'b01,1,0,0,8'h43,0,0));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,1,0,1,8'h44,0,0));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,0,0));
    // protocol errors: IDLE valid without sop, sop mid-packet
    vq.push_back(mk(1,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b10,2'b00,2'b00,8'h00,8'h51, 2'b00,0,0,0,8'h00,1,1));
    vq.push_back(mk(0,1,2'b11,2'b01,2'b01,8'h61,8'h51, 2'b00,0,0,0,8'h00,1,1));
    vq.push_back(mk(0,1,2'b11,2'b01,2'b01,8'h61,8'h51, 2'b01,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b10,2'b00,2'b00,8'h00,8'h51, 2'b00,1,1,1,8'h61,0,1));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b01,2'b01,2'b00,8'h71,8'h00, 2'b00,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b01,2'b01,2'b00,8'h71,8'h00, 2'b01,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b01,2'b01,2'b01,8'h72,8'h00, 2'b01,1,1,0,8'h71,0,1));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,1,1,1,8'h72,0,0));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,0,0));
    // reset mid-packet, then a fresh packet on port 1
    vq.push_back(mk(1,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b01,2'b01,2'b00,8'h81,8'h00, 2'b00,0,0,0,8'h00,1,0));
    vq.push_back(mk(0,1,2'b01,2'b01,2'b00,8'h81,8'h00, 2'b01,0,0,0,8'h00,0,0));
    vq.push_back(mk(0,1,2'b01,2'b00,2'b00,8'h82,8'h00, 2'b01,1,1,0,8'h81,0,0));
    vq.push_back(mk(1,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b01,1,0,0,8'h82,0,0));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,1,0));
    vq.push_back(mk(0,1,2'b10,2'b10,2'b10,8'h00,8'h91, 2'b00,0,0,0,8'h00,1,0));
    vq.push_back(mk(0,1,2'b10,2'b10,2'b10,8'h00,8'h91, 2'b10,0,0,0,8'h00,1,0));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,1,1,1,8'h91,1,0));
    vq.push_back(mk(0,1,2'b00,2'b00,2'b00,8'h00,8'h00, 2'b00,0,0,0,8'h00,1,0));

    drive(vq[0]);
    repeat (2) @(posedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1 drive(vq[i]);
      @(negedge clk);
      check(i, vq[i]);
    end

    // fairness: both ports stream single-beat packets back to back
    @(posedge clk);
    #1 rst = 1'b1;
    in_tlp_valid = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    cpl_tlp_ready = 1'b1;
    in_tlp_valid = 2'b11;
    in_tlp_sop   = 2'b11;
    in_tlp_eop   = 2'b11;
    c0 = 0;
    c1 = 0;
    ex = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = in_tlp_ready & in_tlp_valid;
      if (acc != 2'b00) begin
        nvec++;
        if (acc != (ex ? 2'b10 : 2'b01)) begin
          $display("FAIL fair cycle %0d accept got %b want port %0d",
                   i, acc, ex);
          nerr++;
        end
        if (acc[1]) c1++;
        else c0++;
        ex = ~ex;
      end
      @(posedge clk);
    end
    nvec++;
    if (c0 != 10 || c1 != 10) begin
      $display("FAIL fair counts got %0d/%0d want 10/10", c0, c1);
      nerr++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
